// File: rtl/pattern_hit_counter_if.sv
// Bundle between the pattern detector side, the hit counter and the result consumer.
// The counter uses the slave view; the surrounding logic (or a bench) uses master.
interface pattern_hit_counter_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [1:0]       hit;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] cnt_010;
  logic [CNT_W-1:0] cnt_101;
  logic             sat_010;
  logic             sat_101;
  logic             overrun;

  modport master (
    output en, hit, out_ready,
    input  out_valid, cnt_010, cnt_101, sat_010, sat_101, overrun
  );

  modport slave (
    input  en, hit, out_ready,
    output out_valid, cnt_010, cnt_101, sat_010, sat_101, overrun
  );
endinterface

// File: rtl/pattern_hit_counter.sv
// Counts 010/101 detector hits over windows of WINDOW sampled bits and hands each
// window's counts downstream through a one-deep valid/ready result slot.
module pattern_hit_counter #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input logic             clock,
  input logic             reset,
  pattern_hit_counter_if.slave bus
);

  localparam int POS_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(WINDOW - 1);

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } slot_state_t;

  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_d;
  logic             win_close;

  // Per-channel count including this cycle's hit; index follows the hit bit
  // (1 = 010, 0 = 101) so the closing bit lands in the reported result.
  logic [CNT_W-1:0] acc_res [2];
  logic [1:0]       sat_res;

  slot_state_t      state_q;
  logic [CNT_W-1:0] cnt_010_q;
  logic [CNT_W-1:0] cnt_101_q;
  logic             sat_010_q;
  logic             sat_101_q;
  logic             overrun_q;

  assign win_close = bus.en && (pos_q == POS_LAST);

  always_comb begin
    pos_d = pos_q;
    if (bus.en) begin
      pos_d = win_close ? '0 : pos_q + POS_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [CNT_W-1:0] acc_q;
      logic [CNT_W-1:0] acc_d;
      logic             sat_q;
      logic             sat_d;

      // A hit arriving while already at the ceiling is lost; the sat bit records that.
      always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (bus.hit[gi]) begin
          if (acc_q == CNT_MAX) begin
            sat_d = 1'b1;
          end else begin
            acc_d = acc_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clock) begin
        if (reset || win_close) begin
          acc_q <= '0;
          sat_q <= 1'b0;
        end else if (bus.en) begin
          acc_q <= acc_d;
          sat_q <= sat_d;
        end
      end

      assign acc_res[gi] = acc_d;
      assign sat_res[gi] = sat_d;
    end
  endgenerate

  // Result slot: reloads only on a window close that finds room (empty, or being
  // drained the same cycle); otherwise the new window is dropped and flagged.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_EMPTY;
      cnt_010_q <= '0;
      cnt_101_q <= '0;
      sat_010_q <= 1'b0;
      sat_101_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (win_close) begin
            state_q   <= S_FULL;
            cnt_010_q <= acc_res[1];
            cnt_101_q <= acc_res[0];
            sat_010_q <= sat_res[1];
            sat_101_q <= sat_res[0];
          end
        end
        S_FULL: begin
          if (win_close) begin
            if (bus.out_ready) begin
              cnt_010_q <= acc_res[1];
              cnt_101_q <= acc_res[0];
              sat_010_q <= sat_res[1];
              sat_101_q <= sat_res[0];
            end else begin
              overrun_q <= 1'b1;
            end
          end else if (bus.out_ready) begin
            state_q <= S_EMPTY;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign bus.out_valid = (state_q == S_FULL);
  assign bus.cnt_010   = cnt_010_q;
  assign bus.cnt_101   = cnt_101_q;
  assign bus.sat_010   = sat_010_q;
  assign bus.sat_101   = sat_101_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_pattern_hit_counter.sv
// Drives an 8-bit and a 2-bit counter with identical stimulus and compares both
// against a window-total reference model every checked cycle.
module tb_pattern_hit_counter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pattern_hit_counter_if #(.CNT_W(8)) bus8 ();
  pattern_hit_counter_if #(.CNT_W(2)) bus2 ();

  pattern_hit_counter #(.WINDOW(16), .CNT_W(8)) dut8 (.clock(clk), .reset(rst), .bus(bus8));
  pattern_hit_counter #(.WINDOW(16), .CNT_W(2)) dut2 (.clock(clk), .reset(rst), .bus(bus2));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: unbounded per-window totals, clipped to the count ceiling only when reported.
  int m_pos;
  int m_tot   [2][2];
  bit m_valid [2];
  int m_cnt   [2][2];
  bit m_sat   [2][2];
  bit m_ovr   [2];

  function automatic int cmax(int d);
    return (d == 0) ? 255 : 3;
  endfunction

  function automatic logic [19:0] exp8();
    return {m_valid[0], 8'(m_cnt[0][1]), 8'(m_cnt[0][0]), m_sat[0][1], m_sat[0][0], m_ovr[0]};
  endfunction

  function automatic logic [19:0] obs8();
    return {bus8.out_valid, bus8.cnt_010, bus8.cnt_101, bus8.sat_010, bus8.sat_101, bus8.overrun};
  endfunction

  function automatic logic [7:0] exp2();
    return {m_valid[1], 2'(m_cnt[1][1]), 2'(m_cnt[1][0]), m_sat[1][1], m_sat[1][0], m_ovr[1]};
  endfunction

  function automatic logic [7:0] obs2();
    return {bus2.out_valid, bus2.cnt_010, bus2.cnt_101, bus2.sat_010, bus2.sat_101, bus2.overrun};
  endfunction

  task automatic step(input logic r, input logic e, input logic [1:0] h, input logic rdy);
    bit close;
    rst = r;
    bus8.en = e; bus8.hit = h; bus8.out_ready = rdy;
    bus2.en = e; bus2.hit = h; bus2.out_ready = rdy;
    @(posedge clk);
    cyc++;
    close = e && (m_pos == 15);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        m_valid[d] = 0; m_ovr[d] = 0;
        for (int c = 0; c < 2; c++) begin
          m_tot[d][c] = 0; m_cnt[d][c] = 0; m_sat[d][c] = 0;
        end
      end else begin
        if (e) for (int c = 0; c < 2; c++) m_tot[d][c] += int'(h[c]);
        if (close) begin
          if (!m_valid[d] || rdy) begin
            m_valid[d] = 1;
            for (int c = 0; c < 2; c++) begin
              m_cnt[d][c] = (m_tot[d][c] > cmax(d)) ? cmax(d) : m_tot[d][c];
              m_sat[d][c] = (m_tot[d][c] > cmax(d));
            end
          end else begin
            m_ovr[d] = 1;
          end
          for (int c = 0; c < 2; c++) m_tot[d][c] = 0;
        end else if (m_valid[d] && rdy) begin
          m_valid[d] = 0;
        end
      end
    end
    if (r) m_pos = 0;
    else if (e) m_pos = (m_pos == 15) ? 0 : m_pos + 1;
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 2'b11, 1'b0);
    step(1'b1, 1'b1, 2'b11, 1'b0);
    vectors++;
    if (obs8() !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_dut8 cyc %0d: got %h want 00000", cyc, obs8());
    end
    vectors++;
    if (obs2() !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_dut2 cyc %0d: got %h want 00", cyc, obs2());
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 2'b00, 1'b1);
      vectors++;
      if (bus8.out_valid !== (i == 16)) begin
        miscompares++;
        $display("FAIL reset_window_len en-cycle %0d: out_valid got %b want %b", i, bus8.out_valid, (i == 16));
      end
    end
  endtask

  task automatic test_basic();
    logic [1:0] h;
    step(1'b1, 1'b0, 2'b00, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      h = {(i == 2 || i == 5 || i == 9), (i == 3 || i == 7)};
      step(1'b0, 1'b1, h, 1'b1);
      vectors++;
      if (obs8() !== exp8()) begin
        miscompares++;
        $display("FAIL basic_model cyc %0d: got %h want %h", cyc, obs8(), exp8());
      end
    end
    vectors++;
    if ({bus8.out_valid, bus8.cnt_010, bus8.cnt_101, bus8.sat_010, bus8.sat_101} !== {1'b1, 8'd3, 8'd2, 2'b00}) begin
      miscompares++;
      $display("FAIL basic_result: got v=%b c010=%0d c101=%0d want v=1 c010=3 c101=2",
               bus8.out_valid, bus8.cnt_010, bus8.cnt_101);
    end
    step(1'b0, 1'b0, 2'b00, 1'b1);
    vectors++;
    if (bus8.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_drop: out_valid got %b want 0", bus8.out_valid);
    end
  endtask

  task automatic test_gaps();
    int n_en = 0;
    step(1'b1, 1'b0, 2'b00, 1'b1);
    while (n_en < 16) begin
      step(1'b0, 1'b0, 2'b10, 1'b1);
      vectors++;
      if (bus8.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL gaps_early cyc %0d: out_valid got %b want 0", cyc, bus8.out_valid);
      end
      n_en++;
      step(1'b0, 1'b1, (n_en % 4 == 0) ? 2'b10 : 2'b00, 1'b1);
      vectors++;
      if (obs8() !== exp8()) begin
        miscompares++;
        $display("FAIL gaps_model cyc %0d: got %h want %h", cyc, obs8(), exp8());
      end
    end
    vectors++;
    if ({bus8.out_valid, bus8.cnt_010, bus8.cnt_101} !== {1'b1, 8'd4, 8'd0}) begin
      miscompares++;
      $display("FAIL gaps_result: got v=%b c010=%0d c101=%0d want v=1 c010=4 c101=0",
               bus8.out_valid, bus8.cnt_010, bus8.cnt_101);
    end
  endtask

  task automatic test_backpressure();
    step(1'b1, 1'b0, 2'b00, 1'b0);
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 16; i++) begin
        step(1'b0, 1'b1, (w == 0) ? ((i < 4) ? 2'b10 : 2'b00) : ((i < 2 + w) ? 2'b01 : 2'b00),
             (w == 2 && i == 15));
        vectors++;
        if (obs8() !== exp8()) begin
          miscompares++;
          $display("FAIL bp_model w%0d cyc %0d: got %h want %h", w, cyc, obs8(), exp8());
        end
      end
      if (w == 1) begin
        vectors++;
        if ({bus8.out_valid, bus8.cnt_010, bus8.cnt_101, bus8.overrun} !== {1'b1, 8'd4, 8'd0, 1'b1}) begin
          miscompares++;
          $display("FAIL bp_hold: got v=%b c010=%0d c101=%0d ovr=%b want v=1 c010=4 c101=0 ovr=1",
                   bus8.out_valid, bus8.cnt_010, bus8.cnt_101, bus8.overrun);
        end
      end
    end
    vectors++;
    if ({bus8.out_valid, bus8.cnt_010, bus8.cnt_101, bus8.overrun} !== {1'b1, 8'd0, 8'd4, 1'b1}) begin
      miscompares++;
      $display("FAIL bp_reload: got v=%b c010=%0d c101=%0d ovr=%b want v=1 c010=0 c101=4 ovr=1",
               bus8.out_valid, bus8.cnt_010, bus8.cnt_101, bus8.overrun);
    end
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b0, 2'b00, 1'b1);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 16; i++) begin
        step(1'b0, 1'b1, (w == 0) ? ((i < 5) ? 2'b10 : 2'b00) : ((i == 3) ? 2'b10 : 2'b00), 1'b1);
        vectors++;
        if (obs2() !== exp2()) begin
          miscompares++;
          $display("FAIL sat_model w%0d cyc %0d: got %h want %h", w, cyc, obs2(), exp2());
        end
      end
      vectors++;
      if ({bus2.out_valid, bus2.cnt_010, bus2.sat_010} !== ((w == 0) ? {1'b1, 2'd3, 1'b1} : {1'b1, 2'd1, 1'b0})) begin
        miscompares++;
        $display("FAIL sat_result w%0d: got v=%b c010=%0d sat=%b", w, bus2.out_valid, bus2.cnt_010, bus2.sat_010);
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, (i == 1 || i == 4) ? 2'b10 : 2'b00, 1'b1);
    step(1'b1, 1'b0, 2'b00, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, (i == 6) ? 2'b10 : 2'b00, 1'b1);
      vectors++;
      if (bus8.out_valid !== (i == 16)) begin
        miscompares++;
        $display("FAIL midrst_close en-cycle %0d: out_valid got %b want %b", i, bus8.out_valid, (i == 16));
      end
    end
    vectors++;
    if ({bus8.cnt_010, bus8.cnt_101} !== {8'd1, 8'd0}) begin
      miscompares++;
      $display("FAIL midrst_result: got c010=%0d c101=%0d want 1/0", bus8.cnt_010, bus8.cnt_101);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) < 8),
           2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      vectors++;
      if (obs8() !== exp8()) begin
        miscompares++;
        $display("FAIL rand_dut8 cyc %0d: got %h want %h", cyc, obs8(), exp8());
      end
      vectors++;
      if (obs2() !== exp2()) begin
        miscompares++;
        $display("FAIL rand_dut2 cyc %0d: got %h want %h", cyc, obs2(), exp2());
      end
    end
  endtask

  initial begin
    m_pos = 0;
    rst = 1'b1;
    bus8.en = 1'b0; bus8.hit = 2'b00; bus8.out_ready = 1'b0;
    bus2.en = 1'b0; bus2.hit = 2'b00; bus2.out_ready = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
